// File: rtl/counter_demux.sv
// counter_demux: bank of four wait timers with a binary-selected done flag.
// Optional build macro: COUNTER_DEMUX_PERIODIC_EN (free-running periodic timers).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   restart    synchronous clear of all timers
//   sel        binary timer select
//   sel_onehot one-hot decode of sel
//   flags      raw flag of each timer (bit i = timer i)
//   done       flag of the selected timer
module counter_demux #(
    parameter int SEL_BITS = 2,
    parameter int COUNT0   = 2,
    parameter int COUNT1   = 20,
    parameter int COUNT2   = 2500,
    parameter int COUNT3   = 25000,
    parameter int CW       = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic [SEL_BITS-1:0] sel,
    output logic [3:0]          sel_onehot,
    output logic [3:0]          flags,
    output logic                done
);

    function automatic int term(input int i);
        int t;
        unique case (i)
            0:       t = COUNT0;
            1:       t = COUNT1;
            2:       t = COUNT2;
            default: t = COUNT3;
        endcase
        return t;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_tmr
        // Last counter value before the flag fires; counter never passes it.
        localparam logic [CW-1:0] LAST = CW'(term(i) - 1);

        logic [CW-1:0] cnt;
        logic          flag;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt  <= '0;
                flag <= 1'b0;
            end else if (restart) begin
                cnt  <= '0;
                flag <= 1'b0;
            end else if (cnt == LAST) begin
`ifdef COUNTER_DEMUX_PERIODIC_EN
                cnt  <= '0;
`endif
                flag <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
`ifdef COUNTER_DEMUX_PERIODIC_EN
                flag <= 1'b0;
`endif
            end
        end

        assign flags[i] = flag;
    end

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    assign done = |(flags & sel_onehot);

endmodule

// File: tb/tb_counter_demux.sv
// tb_counter_demux: directed self-checking bench for counter_demux
// (default build: sticky, saturating timers).
module tb_counter_demux;

    logic       clk;
    logic       rst;
    logic       restart;
    logic [1:0] sel;
    logic [3:0] sel_onehot;
    logic [3:0] flags;
    logic       done;

    int checks = 0;
    int errors = 0;

    counter_demux dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .sel        (sel),
        .sel_onehot (sel_onehot),
        .flags      (flags),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b0;
        restart = 1'b0;
        sel     = 2'd0;
        #12;
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // Select sweep while held in reset.
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_onehot", 32'(sel_onehot), 32'(4'b0001 << s));
            chk("rst_sweep_done", 32'(done), 32'h0);
        end

        sel = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("e1_done", 32'(done), 32'h0);
        chk("e1_flags", 32'(flags), 32'h0);
        tick();
        chk("e2_done", 32'(done), 32'h1);
        chk("e2_flags", 32'(flags), 32'h1);
        tick();
        tick();
        chk("sticky_done", 32'(done), 32'h1);

        // Timer 1 after a one-cycle restart pulse.
        sel     = 2'd1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_flags", 32'(flags), 32'h0);
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 2)
                chk("rs_e2_flag0", 32'(flags[0]), 32'h1);
        end
        chk("rs_e19_done", 32'(done), 32'h0);
        tick();
        chk("rs_e20_done", 32'(done), 32'h1);
        chk("rs_e20_flags", 32'(flags), 32'h3);

        // Restart held high keeps everything cleared.
        restart = 1'b1;
        tick();
        tick();
        tick();
        chk("hold_flags", 32'(flags), 32'h0);
        restart = 1'b0;
        tick();
        chk("hold_e1_flags", 32'(flags), 32'h0);

        // Async reset at timer 1 cnt=10, between edges.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        repeat (10) tick();
        chk("pre_arst_flags", 32'(flags), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_flags", 32'(flags), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (19) tick();
        chk("arst_e19_flag1", 32'(flags[1]), 32'h0);
        tick();
        chk("arst_e20_flag1", 32'(flags[1]), 32'h1);
        chk("arst_e20_flags", 32'(flags), 32'h3);

        // Timer 3 long wait, then same-cycle reselect.
        sel     = 2'd3;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        repeat (24999) tick();
        chk("t3_e24999_done", 32'(done), 32'h0);
        chk("t3_e24999_flags", 32'(flags), 32'h7);
        tick();
        chk("t3_e25000_done", 32'(done), 32'h1);
        chk("t3_e25000_flags", 32'(flags), 32'hf);
        sel = 2'd2;
        #1;
        chk("resel_onehot", 32'(sel_onehot), 32'h4);
        chk("resel_done", 32'(done), 32'h1);
        repeat (5) tick();
        chk("sat_flags", 32'(flags), 32'hf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
